// File: rtl/blk_998aca_pkg.sv
// Shared definitions for the iterative restoring divider: FSM encoding,
// default widths and the special-case result constants.
package blk_998aca_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 6;

    localparam logic [DATA_W_DEF-1:0] DIV0_QUOT = {DATA_W_DEF{1'b1}};
    localparam logic [DATA_W_DEF-1:0] SMIN      = {1'b1, {(DATA_W_DEF-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/blk_998aca_if.sv
// Issue/result bundle between the div/divu issue logic (master) and the
// divider cell (slave).
interface blk_998aca_if
    import blk_998aca_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic [DATA_W-1:0] E_src1;
    logic [DATA_W-1:0] E_src2;
    logic              div_start;
    logic              div_signed;
    logic              div_en;
    logic              div_busy;
    logic              div_done;
    logic [DATA_W-1:0] div_quotient;
    logic [DATA_W-1:0] div_remainder;

    modport master (
        output E_src1, E_src2, div_start, div_signed, div_en,
        input  div_busy, div_done, div_quotient, div_remainder
    );

    modport slave (
        input  E_src1, E_src2, div_start, div_signed, div_en,
        output div_busy, div_done, div_quotient, div_remainder
    );
endinterface

// File: rtl/blk_998aca_step.sv
// One combinational restoring-division step on unsigned magnitudes:
// (rem, dvd, dvs) -> (rem', dvd', qbit).
module blk_998aca_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W:0]   i_rem,
    input  logic [DATA_W-1:0] i_dvd,
    input  logic [DATA_W-1:0] i_dvs,
    output logic [DATA_W:0]   o_rem,
    output logic [DATA_W-1:0] o_dvd,
    output logic              o_qbit
);
    logic [DATA_W:0] w_sh;
    logic [DATA_W:0] w_diff;
    logic [DATA_W:0] w_dvs_ext;

    // The incoming remainder is always below the divisor, so its top bit is zero.
    logic w_unused_rem_msb;
    assign w_unused_rem_msb = i_rem[DATA_W];

    assign w_sh      = {i_rem[DATA_W-1:0], i_dvd[DATA_W-1]};
    assign w_dvs_ext = {1'b0, i_dvs};
    assign w_diff    = w_sh - w_dvs_ext;
    assign o_qbit    = (w_sh >= w_dvs_ext);
    assign o_rem     = o_qbit ? w_diff : w_sh;
    assign o_dvd     = {i_dvd[DATA_W-2:0], 1'b0};

endmodule

// File: rtl/blk_998aca.sv
// Iterative radix-2 restoring divider cell: FSM, iteration counter,
// sign/special-case flags and held result registers.
module blk_998aca
    import blk_998aca_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    blk_998aca_if.slave bus
);
    localparam logic [DATA_W-1:0] L_DIV0_QUOT = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] L_SMIN      = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]  L_CNT_LOAD  = CNT_W'(DATA_W - 1);

    function automatic logic [DATA_W-1:0] f_cond_neg(input logic [DATA_W-1:0] v,
                                                     input logic              neg);
        logic signed [DATA_W-1:0] s;
        s = $signed(v);
        return neg ? $unsigned(-s) : v;
    endfunction

    div_state_e        r_state;
    div_state_e        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W:0]   r_rem;
    logic [DATA_W-1:0] r_dvd;
    logic [DATA_W-1:0] r_dvs;
    logic [DATA_W-1:0] r_quo;
    logic [DATA_W-1:0] r_raw_dvd;
    logic [DATA_W-1:0] r_quot_out;
    logic [DATA_W-1:0] r_rem_out;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_div0;
    logic              r_ovf;

    logic              w_last;
    logic              w_src1_neg;
    logic              w_src2_neg;
    logic              w_busy;
    logic              w_done;
    logic [DATA_W:0]   w_rem_nxt;
    logic [DATA_W-1:0] w_dvd_nxt;
    logic              w_qbit;

    assign w_last     = (r_cnt == '0);
    assign w_src1_neg = bus.div_signed && bus.E_src1[DATA_W-1];
    assign w_src2_neg = bus.div_signed && bus.E_src2[DATA_W-1];

    blk_998aca_step #(.DATA_W(DATA_W)) u_step (
        .i_rem  (r_rem),
        .i_dvd  (r_dvd),
        .i_dvs  (r_dvs),
        .o_rem  (w_rem_nxt),
        .o_dvd  (w_dvd_nxt),
        .o_qbit (w_qbit)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else if (bus.div_en) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.div_start) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last) w_state_nxt = ST_FIX;
            ST_FIX:  w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != ST_IDLE);
        w_done = (r_state == ST_DONE);
    end

    // Everything below freezes whenever div_en is low; RUN always executes the
    // full DATA_W steps so special cases keep the same latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_rem      <= '0;
            r_dvd      <= '0;
            r_dvs      <= '0;
            r_quo      <= '0;
            r_raw_dvd  <= '0;
            r_quot_out <= '0;
            r_rem_out  <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div0     <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (bus.div_en) begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.div_start) begin
                        r_dvd     <= f_cond_neg(bus.E_src1, w_src1_neg);
                        r_dvs     <= f_cond_neg(bus.E_src2, w_src2_neg);
                        r_rem     <= '0;
                        r_quo     <= '0;
                        r_raw_dvd <= bus.E_src1;
                        r_neg_q   <= w_src1_neg ^ w_src2_neg;
                        r_neg_r   <= w_src1_neg;
                        r_div0    <= (bus.E_src2 == '0);
                        r_ovf     <= bus.div_signed && (bus.E_src1 == L_SMIN)
                                     && (bus.E_src2 == L_DIV0_QUOT);
                        r_cnt     <= L_CNT_LOAD;
                    end
                end
                ST_RUN: begin
                    r_rem <= w_rem_nxt;
                    r_dvd <= w_dvd_nxt;
                    r_quo <= {r_quo[DATA_W-2:0], w_qbit};
                    if (!w_last) r_cnt <= r_cnt - CNT_W'(1);
                end
                ST_FIX: begin
                    if (r_div0) begin
                        r_quot_out <= L_DIV0_QUOT;
                        r_rem_out  <= r_raw_dvd;
                    end else if (r_ovf) begin
                        r_quot_out <= L_SMIN;
                        r_rem_out  <= '0;
                    end else begin
                        r_quot_out <= f_cond_neg(r_quo, r_neg_q);
                        r_rem_out  <= f_cond_neg(r_rem[DATA_W-1:0], r_neg_r);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.div_busy      = w_busy;
    assign bus.div_done      = w_done;
    assign bus.div_quotient  = r_quot_out;
    assign bus.div_remainder = r_rem_out;

endmodule

// File: tb/tb_blk_998aca.sv
// Self-checking bench for blk_998aca: table of divide vectors plus stall,
// ignored-start and mid-operation reset sequences.
module tb_blk_998aca;
    import blk_998aca_pkg::*;

    localparam int W = DATA_W_DEF;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sgn;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    vec_t vecs[13];

    always #5 clk = ~clk;

    blk_998aca_if #(.DATA_W(W)) bus();

    blk_998aca #(.DATA_W(W), .CNT_W(CNT_W_DEF)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                                input logic [W-1:0] q, input logic [W-1:0] r);
        vec_t v;
        v.a = a; v.b = b; v.sgn = sgn; v.q = q; v.r = r;
        return v;
    endfunction

    task automatic chkv(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkint(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Accept happens in cycle 0; cycles are counted from the following edge.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                           input logic [W-1:0] eq, input logic [W-1:0] er, input int lat,
                           input int st_from, input int st_len, input int p1, input int p2,
                           input logic [W-1:0] prev_q);
        exp_t e;
        exp_t got;
        int   cyc;
        bit   seen;
        e.q = eq; e.r = er; e.lat = lat;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.E_src1 = a; bus.E_src2 = b; bus.div_signed = sgn;
        bus.div_start = 1'b1; bus.div_en = 1'b1;
        cyc = 0; seen = 0;
        while (!seen && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            chk1("busy", bus.div_busy, 1'b1);
            if (bus.div_done) begin
                seen = 1;
                got = sb.pop_front();
                chkint("latency", cyc, got.lat);
                chkv("quotient", bus.div_quotient, got.q);
                chkv("remainder", bus.div_remainder, got.r);
            end else if (cyc >= st_from && cyc < st_from + st_len) begin
                chkv("stall_hold_quot", bus.div_quotient, prev_q);
            end
            bus.div_start = (cyc == p1) || (cyc == p2);
            if (bus.div_start) begin
                bus.E_src1 = 32'd5; bus.E_src2 = 32'd1; bus.div_signed = 1'b0;
            end
            bus.div_en = !(cyc >= st_from && cyc < st_from + st_len);
        end
        if (!seen) begin
            n_checks++; n_fail++;
            $display("FAIL done_timeout: no div_done after %0d cycles", cyc);
            got = sb.pop_front();
        end
        @(posedge clk); #1;
        bus.div_start = 1'b0; bus.div_en = 1'b1;
        chk1("done_pulse", bus.div_done, 1'b0);
        chk1("idle_busy", bus.div_busy, 1'b0);
        chkv("hold_quot", bus.div_quotient, eq);
        chkv("hold_rem", bus.div_remainder, er);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] prev_q;
        int           ndone;

        vecs[0]  = mk(32'd100,      32'd7,        1'b0, 32'd14,       32'd2);
        vecs[1]  = mk(32'hFFFFFF9C, 32'd7,        1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE);
        vecs[2]  = mk(32'd100,      32'hFFFFFFF9, 1'b1, 32'hFFFFFFF2, 32'd2);
        vecs[3]  = mk(32'h1234,     32'd0,        1'b0, DIV0_QUOT,    32'h1234);
        vecs[4]  = mk(SMIN,         32'hFFFFFFFF, 1'b1, SMIN,         32'd0);
        vecs[5]  = mk(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 32'd14,       32'hFFFFFFFE);
        vecs[6]  = mk(32'hFFFFFF9C, 32'd7,        1'b0, 32'h24924916, 32'd2);
        vecs[7]  = mk(32'hFFFFFFFB, 32'd0,        1'b1, DIV0_QUOT,    32'hFFFFFFFB);
        vecs[8]  = mk(32'd7,        32'd100,      1'b0, 32'd0,        32'd7);
        vecs[9]  = mk(SMIN,         32'd2,        1'b1, 32'hC0000000, 32'd0);
        vecs[10] = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd1,        32'd0);
        vecs[11] = mk(SMIN,         32'd1,        1'b1, SMIN,         32'd0);
        vecs[12] = mk(SMIN,         32'hFFFFFFFF, 1'b0, 32'd0,        SMIN);

        reset_n = 1'b0;
        bus.E_src1 = '0; bus.E_src2 = '0;
        bus.div_start = 1'b0; bus.div_signed = 1'b0; bus.div_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_busy", bus.div_busy, 1'b0);
        chk1("rst_done", bus.div_done, 1'b0);
        chkv("rst_quot", bus.div_quotient, '0);
        chkv("rst_rem", bus.div_remainder, '0);
        reset_n = 1'b1;

        // Start with div_en low must not be accepted.
        @(posedge clk); #1;
        bus.E_src1 = 32'd9; bus.E_src2 = 32'd3; bus.div_start = 1'b1; bus.div_en = 1'b0;
        @(posedge clk); #1;
        bus.div_start = 1'b0; bus.div_en = 1'b1;
        chk1("en0_start_ignored", bus.div_busy, 1'b0);
        @(posedge clk); #1;
        chk1("en0_still_idle", bus.div_busy, 1'b0);

        prev_q = '0;
        for (int i = 0; i < 13; i++) begin
            run_div(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].q, vecs[i].r, 34,
                    1000, 0, -1, -1, prev_q);
            prev_q = vecs[i].q;
        end

        run_div(32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 39, 10, 5, -1, -1, prev_q);
        prev_q = 32'hFFFFFFFF;

        run_div(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 34, 1000, 0, 10, 34, prev_q);
        @(posedge clk); #1;
        chk1("no_queued_start", bus.div_busy, 1'b0);

        // Reset in the middle of RUN: abort, clear outputs, no done afterwards.
        sb.push_back('{q: 32'h55555555, r: 32'd0, lat: 34});
        @(posedge clk); #1;
        bus.E_src1 = 32'hFFFFFFFF; bus.E_src2 = 32'd3; bus.div_signed = 1'b0;
        bus.div_start = 1'b1; bus.div_en = 1'b1;
        @(posedge clk); #1;
        bus.div_start = 1'b0;
        repeat (14) begin @(posedge clk); #1; end
        chk1("busy_before_reset", bus.div_busy, 1'b1);
        reset_n = 1'b0;
        sb.delete();
        #1;
        chk1("midrst_busy", bus.div_busy, 1'b0);
        chk1("midrst_done", bus.div_done, 1'b0);
        chkv("midrst_quot", bus.div_quotient, '0);
        chkv("midrst_rem", bus.div_remainder, '0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.div_done) ndone++;
        end
        chkint("no_done_after_reset", ndone, 0);

        run_div(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 34, 1000, 0, -1, -1, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
